// File: rtl/four_bit_down_counter.sv
// Loadable 4-bit down counter used as a terminal-count timer: a borrow chain of
// And/ThreeAnd/FourAnd gates feeding two levels of s2 mux / mux-flop cells per bit.

module And (
   input  logic a_i,
   input  logic b_i,
   output logic y_o
);
   assign y_o = a_i & b_i;
endmodule

module ThreeAnd (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic y_o
);
   assign y_o = a_i & b_i & c_i;
endmodule

module FourAnd (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   input  logic d_i,
   output logic y_o
);
   assign y_o = a_i & b_i & c_i & d_i;
endmodule

module s2_mux (
   input  logic sel_i,
   input  logic d0_i,
   input  logic d1_i,
   output logic y_o
);
   // Two-way select, d1 wins when sel is high.
   always_comb begin
      y_o = d0_i;
      if (sel_i) begin
         y_o = d1_i;
      end else begin
         y_o = d0_i;
      end
   end
endmodule

module s2_mux_flop (
   input  logic clk_i,
   input  logic clr_i,
   input  logic sel_i,
   input  logic d0_i,
   input  logic d1_i,
   output logic q_o
);
   logic clr_n;
   logic q_d;
   logic q_q;

   assign clr_n = ~clr_i;

   // Input select ahead of the storage element.
   always_comb begin
      q_d = d0_i;
      if (sel_i) begin
         q_d = d1_i;
      end else begin
         q_d = d0_i;
      end
   end

   // Storage element; clr empties it at once, without waiting for a clock.
   always_ff @(posedge clk_i or negedge clr_n) begin
      if (!clr_n) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;
endmodule

module four_bit_down_counter #(
   parameter logic WRAP = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_value,
   input  logic       count_enable,
   output logic [3:0] count,
   output logic       zero,
   output logic       done
);
   logic       clr;
   logic [3:0] count_q;
   logic [3:0] count_n;
   logic [3:0] tog;
   logic [3:0] hold_tog;
   logic       zero_s;
   logic       dec_ok;
   logic       dec;
   logic       is_one;
   logic       done_d;
   logic       done_q;

   assign clr     = ~reset;
   assign count_n = ~count_q;

   FourAnd u_zero (.a_i(count_n[0]), .b_i(count_n[1]), .c_i(count_n[2]), .d_i(count_n[3]), .y_o(zero_s));

   // At zero a decrement is only real when wrapping; otherwise the count saturates.
   assign dec_ok = WRAP | ~zero_s;
   And u_dec (.a_i(count_enable), .b_i(dec_ok), .y_o(dec));

   assign tog[0] = dec;
   And      u_tog1 (.a_i(dec), .b_i(count_n[0]), .y_o(tog[1]));
   ThreeAnd u_tog2 (.a_i(dec), .b_i(count_n[1]), .c_i(count_n[0]), .y_o(tog[2]));
   FourAnd  u_tog3 (.a_i(dec), .b_i(count_n[2]), .c_i(count_n[1]), .d_i(count_n[0]), .y_o(tog[3]));

   genvar i;
   generate
      for (i = 0; i < 4; i = i + 1) begin : g_bit
         s2_mux u_hold_tog (
            .sel_i (tog[i]),
            .d0_i  (count_q[i]),
            .d1_i  (count_n[i]),
            .y_o   (hold_tog[i])
         );
         s2_mux_flop u_load (
            .clk_i (clk),
            .clr_i (clr),
            .sel_i (load),
            .d0_i  (hold_tog[i]),
            .d1_i  (load_value[i]),
            .q_o   (count_q[i])
         );
      end
   endgenerate

   // done fires only on a real 1->0 decrement; a load always clears it.
   FourAnd u_is_one (.a_i(count_q[0]), .b_i(count_n[1]), .c_i(count_n[2]), .d_i(count_n[3]), .y_o(is_one));
   And     u_done   (.a_i(dec), .b_i(is_one), .y_o(done_d));

   s2_mux_flop u_done_ff (
      .clk_i (clk),
      .clr_i (clr),
      .sel_i (load),
      .d0_i  (done_d),
      .d1_i  (1'b0),
      .q_o   (done_q)
   );

   assign count = count_q;
   assign zero  = zero_s;
   assign done  = done_q;
endmodule

// File: tb/tb_four_bit_down_counter.sv
// Bench for four_bit_down_counter: a saturating and a wrapping instance share stimulus;
// directed table, reset corner sequences, then random traffic against a rule-level model.

module tb_four_bit_down_counter;
   logic       clk;
   logic       reset;
   logic       load;
   logic [3:0] load_value;
   logic       count_enable;
   logic [3:0] count0, count1;
   logic       zero0, zero1;
   logic       done0, done1;

   int n_checks = 0;
   int n_fail   = 0;

   four_bit_down_counter #(.WRAP(1'b0)) u_sat (
      .clk(clk), .reset(reset), .load(load), .load_value(load_value),
      .count_enable(count_enable), .count(count0), .zero(zero0), .done(done0)
   );

   four_bit_down_counter #(.WRAP(1'b1)) u_wrap (
      .clk(clk), .reset(reset), .load(load), .load_value(load_value),
      .count_enable(count_enable), .count(count1), .zero(zero1), .done(done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       ld;
      logic [3:0] lv;
      logic       en;
      logic [3:0] c0;
      logic       d0;
      logic [3:0] c1;
      logic       d1;
   } vec_t;

   vec_t vecs[$];

   int mc[2];
   bit md[2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] c0, input logic d0,
                          input logic [3:0] c1, input logic d1);
      chk({tag, " sat count"}, 32'(count0), 32'(c0));
      chk({tag, " sat zero"},  32'(zero0),  32'(c0 == 4'd0));
      chk({tag, " sat done"},  32'(done0),  32'(d0));
      chk({tag, " wrap count"}, 32'(count1), 32'(c1));
      chk({tag, " wrap zero"},  32'(zero1),  32'(c1 == 4'd0));
      chk({tag, " wrap done"},  32'(done1),  32'(d1));
   endtask

   // Rule-level reference: applies the priority list to plain integers.
   task automatic model_edge(input bit ld, input int lv, input bit en);
      for (int w = 0; w < 2; w++) begin
         if (ld) begin
            mc[w] = lv;
            md[w] = 1'b0;
         end else if (en && mc[w] != 0) begin
            md[w] = (mc[w] == 1);
            mc[w] = mc[w] - 1;
         end else if (en && w == 1) begin
            mc[w] = 15;
            md[w] = 1'b0;
         end else begin
            md[w] = 1'b0;
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      load = 1'b0;
      load_value = 4'd0;
      count_enable = 1'b0;

      //            ld    lv     en    c0     d0    c1     d1
      vecs.push_back('{1'b1, 4'd5,  1'b1, 4'd5,  1'b0, 4'd5,  1'b0});
      vecs.push_back('{1'b0, 4'd0,  1'b1, 4'd4,  1'b0, 4'd4,  1'b0});
      vecs.push_back('{1'b0, 4'd0,  1'b1, 4'd3,  1'b0, 4'd3,  1'b0});
      vecs.push_back('{1'b0, 4'd0,  1'b1, 4'd2,  1'b0, 4'd2,  1'b0});
      vecs.push_back('{1'b0, 4'd0,  1'b1, 4'd1,  1'b0, 4'd1,  1'b0});
      vecs.push_back('{1'b0, 4'd0,  1'b1, 4'd0,  1'b1, 4'd0,  1'b1});
      vecs.push_back('{1'b0, 4'd0,  1'b1, 4'd0,  1'b0, 4'd15, 1'b0});
      vecs.push_back('{1'b0, 4'd0,  1'b1, 4'd0,  1'b0, 4'd14, 1'b0});
      vecs.push_back('{1'b0, 4'd0,  1'b1, 4'd0,  1'b0, 4'd13, 1'b0});
      vecs.push_back('{1'b1, 4'd7,  1'b0, 4'd7,  1'b0, 4'd7,  1'b0});
      vecs.push_back('{1'b1, 4'd12, 1'b1, 4'd12, 1'b0, 4'd12, 1'b0});
      vecs.push_back('{1'b1, 4'd0,  1'b1, 4'd0,  1'b0, 4'd0,  1'b0});
      vecs.push_back('{1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 4'd0,  1'b0});
      vecs.push_back('{1'b1, 4'd1,  1'b0, 4'd1,  1'b0, 4'd1,  1'b0});
      vecs.push_back('{1'b0, 4'd0,  1'b1, 4'd0,  1'b1, 4'd0,  1'b1});
      vecs.push_back('{1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 4'd0,  1'b0});
      vecs.push_back('{1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 4'd0,  1'b0});
      vecs.push_back('{1'b1, 4'd10, 1'b0, 4'd10, 1'b0, 4'd10, 1'b0});
      vecs.push_back('{1'b0, 4'd3,  1'b0, 4'd10, 1'b0, 4'd10, 1'b0});
      vecs.push_back('{1'b0, 4'd3,  1'b0, 4'd10, 1'b0, 4'd10, 1'b0});
      vecs.push_back('{1'b0, 4'd3,  1'b0, 4'd10, 1'b0, 4'd10, 1'b0});
      vecs.push_back('{1'b0, 4'd3,  1'b0, 4'd10, 1'b0, 4'd10, 1'b0});
      vecs.push_back('{1'b0, 4'd0,  1'b1, 4'd9,  1'b0, 4'd9,  1'b0});
      vecs.push_back('{1'b1, 4'd1,  1'b1, 4'd1,  1'b0, 4'd1,  1'b0});
      vecs.push_back('{1'b1, 4'd8,  1'b1, 4'd8,  1'b0, 4'd8,  1'b0});
      vecs.push_back('{1'b0, 4'd0,  1'b1, 4'd7,  1'b0, 4'd7,  1'b0});

      repeat (2) @(negedge clk);
      chk_all("reset", 4'd0, 1'b0, 4'd0, 1'b0);
      reset = 1'b1;

      foreach (vecs[k]) begin
         load = vecs[k].ld;
         load_value = vecs[k].lv;
         count_enable = vecs[k].en;
         @(negedge clk);
         chk_all($sformatf("vec%0d", k), vecs[k].c0, vecs[k].d0, vecs[k].c1, vecs[k].d1);
      end

      // Asynchronous reset mid-cycle from count 9, then held across an edge.
      load = 1'b1; load_value = 4'd9; count_enable = 1'b0;
      @(negedge clk);
      load = 1'b0;
      chk_all("preload9", 4'd9, 1'b0, 4'd9, 1'b0);
      #2 reset = 1'b0;
      #1 chk_all("async_rst", 4'd0, 1'b0, 4'd0, 1'b0);
      load = 1'b1; load_value = 4'd3; count_enable = 1'b1;
      @(negedge clk);
      chk_all("rst_blocks", 4'd0, 1'b0, 4'd0, 1'b0);
      reset = 1'b1; load = 1'b0; count_enable = 1'b0;

      // Reset landing while done is high must kill the pulse at once.
      load = 1'b1; load_value = 4'd1;
      @(negedge clk);
      load = 1'b0; count_enable = 1'b1;
      @(negedge clk);
      chk_all("done_hi", 4'd0, 1'b1, 4'd0, 1'b1);
      #2 reset = 1'b0;
      #1 chk_all("rst_done", 4'd0, 1'b0, 4'd0, 1'b0);
      count_enable = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      mc[0] = 0; mc[1] = 0; md[0] = 1'b0; md[1] = 1'b0;
      for (int n = 0; n < 400; n++) begin
         load = ($urandom_range(7, 0) == 0);
         load_value = 4'($urandom_range(15, 0));
         count_enable = ($urandom_range(3, 0) != 0);
         model_edge(load, int'(load_value), count_enable);
         @(negedge clk);
         chk_all($sformatf("rnd%0d", n), 4'(mc[0]), md[0], 4'(mc[1]), md[1]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/four_bit_down_counter.md
# four_bit_down_counter

Loadable 4-bit down counter. It is the decrementing counterpart of the existing up counter and is used as a terminal-count timer: load a start value, decrement on enable, flag arrival at zero. Controllers use it for remaining-iteration counts, where the up counter is used for elapsed counts. Implementation uses the team's s2 mux-flop cells plus the And/ThreeAnd/FourAnd gate cells, consistent with the up counter.

## Interface
- WRAP, default 0: 0 = counter holds at 0 when decremented at 0; 1 = counter wraps from 0 to 15.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- load  input  1  synchronous load strobe.
- load_value  input  4  value captured when load=1.
- count_enable  input  1  decrement request.
- count  output  4  current register value.
- zero  output  1  combinational; 1 when count == 0.
- done  output  1  registered one-cycle pulse marking arrival at 0 by decrement.

## Operation
- Reset (reset=0, asynchronous, no clock needed): count=0, done=0, zero=1. All register updates are blocked while reset=0.
- Per rising edge with reset=1, first matching rule wins:
  - load=1: count <= load_value; done <= 0.
  - count_enable=1 and count != 0: count <= count - 1. Set done <= 1 only if count == 1; otherwise done <= 0.
  - count_enable=1, count == 0, WRAP=1: count <= 15; done <= 0.
  - count_enable=1, count == 0, WRAP=0: count holds at 0; done <= 0.
  - Otherwise: count holds; done <= 0.
- load has priority over count_enable on the same edge. Loading 0 never produces done.
- Borrow chain, structural: bit i toggles when decrementing and bits [i-1:0] are all 0.
  - Bit 0 toggle term: dec.
  - Bit 1 toggle term: dec & ~count[0].
  - Bit 2 toggle term: ThreeAnd of dec, ~count[1], ~count[0].
  - Bit 3 toggle term: FourAnd of dec, ~count[2], ~count[1], ~count[0].
  - dec = count_enable & (WRAP | ~zero).
- Load path: per bit, a second s2 select level picks load_value[i] over the hold/toggle result.
- Async reset drives the s2 clr inputs, with polarity inverted as required.
- zero is a 4-input NOR of count. It has no register stage.

## Timing
- All state changes on the rising edge of clk, except reset assertion, which takes effect immediately.
- Load latency: count equals load_value one cycle after the edge where load=1.
- Decrement latency: one edge per step. From load value N with enable held high, zero rises after N edges.
- done timing: done is high for exactly the one cycle following the edge that moved count from 1 to 0.
  - done coincides with the first cycle of zero=1 after that transition.
  - done then falls on the next edge.
- With enable held at 0 under WRAP=0, done does not re-fire. A later load is required before done can pulse again.
- Reset deassertion: the first active edge is the next rising clk edge after reset=1. Deassertion is synchronised upstream.
- Reset mid-count: count goes to 0 and done to 0 immediately, mid-cycle. done must not pulse as a result of reset.

## Test plan
- Reset: assert reset=0 mid-cycle with count=9 -> count=0, zero=1, done=0 before the next clk edge.
- Load and count down: load_value=5, load=1 for one edge, then count_enable=1 -> count sequence 5,4,3,2,1,0. done=1 for exactly the one cycle where count first reads 0.
- Saturation (WRAP=0): count=0, count_enable=1 for 3 edges -> count stays 0, done stays 0, zero stays 1.
- Wrap (WRAP=1): load 1, then enable for 3 edges -> count sequence 1,0,15,14. done pulses once, at the 1->0 step.
- Priority: count=7, load=1 with load_value=12 and count_enable=1 on the same edge -> count=12, no decrement. Load 0 -> done stays 0.
- Hold: count=10, count_enable=0 for 4 edges -> count stays 10. Then enable for 1 edge -> count=9.
